// File: rtl/prbs_descrambler_pkg.sv
// rtl/prbs_descrambler_pkg.sv - shared PRBS15 constants and FSM state type
// Used by the scrambler and descrambler so both ends agree on LFSR layout.
package prbs_descrambler_pkg;

    localparam int LFSR_W = 15;
    localparam int TAP_HI = 14;
    localparam int TAP_LO = 13;
    localparam logic [LFSR_W-1:0] SEED_DEFAULT_C = 15'h4A80;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/prbs_descrambler_if.sv
// rtl/prbs_descrambler_if.sv - frame control, byte stream handshakes and status
// master: frame source / byte producer / byte consumer (drives seed, frame_len,
//         frame_start, in_data, in_valid, out_ready)
// slave : the descrambler (drives in_ready, out_data, out_valid, busy, frame_done)
interface prbs_descrambler_if #(
    parameter int LEN_W = 16
);
    import prbs_descrambler_pkg::*;

    logic [LFSR_W-1:0] seed;
    logic [LEN_W-1:0]  frame_len;
    logic              frame_start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              frame_done;

    modport master (
        output seed, frame_len, frame_start, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, busy, frame_done
    );

    modport slave (
        input  seed, frame_len, frame_start, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, busy, frame_done
    );

endinterface

// File: rtl/prbs15_step8.sv
// rtl/prbs15_step8.sv - eight PRBS15 steps in one cycle plus keystream byte
// Ports: state_i (current LFSR), state_o (LFSR after 8 steps),
//        keystream_o (bit n = feedback of step n, LSB first).
module prbs15_step8
    import prbs_descrambler_pkg::*;
(
    input  logic [LFSR_W-1:0] state_i,
    output logic [LFSR_W-1:0] state_o,
    output logic [7:0]        keystream_o
);

    always_comb begin
        logic [LFSR_W-1:0] s;
        logic              fb;
        s           = state_i;
        keystream_o = 8'h00;
        for (int n = 0; n < 8; n++) begin
            fb             = s[TAP_HI] ^ s[TAP_LO];
            keystream_o[n] = fb;
            s              = {s[LFSR_W-2:0], fb};
        end
        state_o = s;
    end

endmodule

// File: rtl/prbs_descrambler.sv
// rtl/prbs_descrambler.sv - framed PRBS15 byte descrambler with one-deep output register
// Ports: clk, rst (async active-low, release synchronised internally),
//        bus (slave modport: seed/frame_len/frame_start, in_* and out_* handshakes,
//        busy, frame_done).
module prbs_descrambler
    import prbs_descrambler_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED_DEFAULT = SEED_DEFAULT_C,
    parameter int                LEN_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    prbs_descrambler_if.slave    bus
);

    // Assert asynchronously, release on the second clk edge.
    logic rst_meta_q;
    logic rst_sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    state_t            state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              frame_done_q, frame_done_d;

    logic [LFSR_W-1:0] lfsr_step;
    logic [7:0]        keystream;
    logic [LFSR_W-1:0] load_seed;
    logic              in_ready;
    logic              accept;
    logic              last_byte;

    prbs15_step8 u_step (
        .state_i     (lfsr_q),
        .state_o     (lfsr_step),
        .keystream_o (keystream)
    );

    assign load_seed = (bus.seed == '0) ? SEED_DEFAULT : bus.seed;

    // frame_start blocks the input so a byte is never consumed with a stale key.
    assign in_ready  = (state_q == ST_RUN) && !bus.frame_start
                       && (!out_valid_q || bus.out_ready);
    assign accept    = in_ready && bus.in_valid;
    // Counter value 1 means this byte empties it; a load of 0 wraps to 2^LEN_W bytes.
    assign last_byte = accept && (cnt_q == LEN_W'(1));

    // FSM: state register
    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (bus.frame_start) begin
            state_d = ST_RUN;
        end else if (last_byte) begin
            state_d = ST_IDLE;
        end
    end

    // FSM: outputs
    always_comb begin
        bus.busy       = (state_q == ST_RUN);
        bus.in_ready   = in_ready;
        bus.out_data   = out_data_q;
        bus.out_valid  = out_valid_q;
        bus.frame_done = frame_done_q;
    end

    // Datapath next state
    always_comb begin
        lfsr_d       = lfsr_q;
        cnt_d        = cnt_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        frame_done_d = 1'b0;

        if (bus.frame_start) begin
            lfsr_d = load_seed;
            cnt_d  = bus.frame_len;
        end else if (accept) begin
            lfsr_d       = lfsr_step;
            cnt_d        = cnt_q - LEN_W'(1);
            frame_done_d = last_byte;
        end

        // A pending byte survives frame_start; it only leaves via out_ready.
        if (accept) begin
            out_data_d  = bus.in_data ^ keystream;
            out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            lfsr_q       <= SEED_DEFAULT;
            cnt_q        <= '0;
            out_data_q   <= 8'h00;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            lfsr_q       <= lfsr_d;
            cnt_q        <= cnt_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: doc/prbs_descrambler.md
PRBS_DESCRAMBLER -- requirements
Module: prbs_descrambler

Interface
REQ-001 Parameter SEED_DEFAULT, default 15'h4A80, is the LFSR seed substituted whenever the loaded seed is all-zero.
REQ-002 Parameter LEN_W, default 16, is the width of frame_len and of the byte counter.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 seed  input  15  LFSR seed; sampled only on an accepted frame_start.
REQ-006 frame_len  input  LEN_W  bytes per frame; sampled with seed; 0 means 2^LEN_W bytes.
REQ-007 frame_start  input  1  single-cycle pulse that starts a frame or restarts the current one.
REQ-008 in_data  input  8  scrambled byte, LSB first in keystream order.
REQ-009 in_valid / in_ready  input / output  1 each  input handshake; a byte transfers when both are high.
REQ-010 out_data  output  8  descrambled byte.
REQ-011 out_valid / out_ready  output / input  1 each  output handshake; a byte transfers when both are high.
REQ-012 busy  output  1  high in state RUN.
REQ-013 frame_done  output  1  single-cycle pulse after the last byte of a frame is accepted.

Function
REQ-014 The LFSR is 15 bits (s[14:0]), polynomial 1+x^14+x^15, fb = s[14]^s[13], and each step sets next s = {s[13:0], fb}.
REQ-015 Per accepted byte, the LFSR advances exactly 8 steps in one cycle, and out bit n = in_data[n] ^ fb(step n) for n = 0..7.
REQ-016 The FSM has two states: IDLE and RUN.
REQ-017 In IDLE, in_ready = 0 and input bytes are not consumed.
REQ-018 frame_start in any state loads s <= (seed==0 ? SEED_DEFAULT : seed), loads the remaining-byte counter from frame_len, and enters RUN on the next cycle.
REQ-019 In RUN, in_ready = (!out_valid || out_ready); the block has a single output register and no bubble under continuous flow.
REQ-020 Latency is 1 cycle: a byte accepted at edge k appears on out_data with out_valid high after edge k.
REQ-021 While out_valid && !out_ready, out_data and out_valid are held stable.
REQ-022 When the counter reaches zero on an accepted byte, the FSM returns to IDLE and frame_done pulses for one cycle, coincident with that last byte's out_valid.
REQ-023 The counter decrements modulo 2^LEN_W, so frame_len = 0 yields exactly 2^LEN_W bytes.
REQ-024 frame_start in the same cycle as an input transfer takes priority: the byte is not accepted, in_ready is forced to 0 that cycle, and the seed is reloaded.
REQ-025 frame_start while an output byte is pending does not drop that byte; the byte is delivered unchanged.
REQ-026 frame_start on the same cycle as the final byte suppresses frame_done.
REQ-027 With the LFSR stepping rules above, state s never becomes all-zero after a load.

Reset
REQ-028 While rst = 0, the block is asynchronously forced to: state IDLE, s = SEED_DEFAULT, counter = 0, out_data = 8'h00, out_valid = 0, in_ready = 0, busy = 0, frame_done = 0.
REQ-029 Reset asserted mid-frame discards any pending output byte and the frame; after release, the block waits in IDLE for frame_start.
REQ-030 Reset release is synchronised to clk internally, so the first active edge after release is clean.

Structure
REQ-031 A shared package holds the LFSR width (15), the tap positions (14, 13), SEED_DEFAULT and the state enumeration, shared with the scrambler.
REQ-032 The 8-step LFSR advance plus keystream byte is one combinational sub-module, prbs15_step8, reused by the scrambler and the descrambler.

Verification
REQ-033 Seed 15'h0001, frame_len 2, in bytes 0xA5 then 0x00 with out_ready = 1 -> out bytes 0xA5 then 0x60, and frame_done pulses with the second byte.
REQ-034 Seed 0 -> output is identical to a run with seed 15'h4A80 on the same input.
REQ-035 Loopback through the scrambler with the same seed, 64 random bytes -> output equals the original bytes, and out_valid/in_valid are each high for 64 cycles with no bubbles.
REQ-036 out_ready held low for 5 cycles mid-frame -> out_data stays stable, in_ready = 0, and no byte is lost or duplicated.
REQ-037 frame_start after byte 3 of a 10-byte frame (seed 1) -> pending byte 3 is delivered, and the next byte is descrambled with keystream 0x00 (restarted).
REQ-038 rst pulled low mid-frame -> out_valid = 0 and busy = 0 immediately, and in_ready stays 0 until a new frame_start.
